// File: rtl/rmt_recovery_walker_if.sv
// Bundle between the rename-map recovery walker, the ActiveList read ports and the
// RMT restore write ports. The walker side is the master.
interface rmt_recovery_walker_if #(
  parameter int AL_INDEX_WIDTH = 6,
  parameter int WALK_WIDTH     = 2,
  parameter int LREG_WIDTH     = 5,
  parameter int PREG_WIDTH     = 7
) ();

  logic                                      toRecoveryPhase;
  logic [AL_INDEX_WIDTH-1:0]                 flushRangeHeadPtr;
  logic [AL_INDEX_WIDTH-1:0]                 flushRangeTailPtr;

  logic [WALK_WIDTH-1:0]                     alReadEn;
  logic [WALK_WIDTH-1:0][AL_INDEX_WIDTH-1:0] alReadPtr;
  logic [WALK_WIDTH-1:0]                     alReadWriteReg;
  logic [WALK_WIDTH-1:0][LREG_WIDTH-1:0]     alReadLogDst;
  logic [WALK_WIDTH-1:0][PREG_WIDTH-1:0]     alReadPrevPhyDst;

  logic [WALK_WIDTH-1:0]                     rmtWriteEn;
  logic [WALK_WIDTH-1:0][LREG_WIDTH-1:0]     rmtWriteLogReg;
  logic [WALK_WIDTH-1:0][PREG_WIDTH-1:0]     rmtWritePhyReg;

  logic                                      renameLogicRecoveryRMT;

  modport master (
    input  toRecoveryPhase, flushRangeHeadPtr, flushRangeTailPtr,
    output alReadEn, alReadPtr,
    input  alReadWriteReg, alReadLogDst, alReadPrevPhyDst,
    output rmtWriteEn, rmtWriteLogReg, rmtWritePhyReg,
    output renameLogicRecoveryRMT
  );

  modport slave (
    output toRecoveryPhase, flushRangeHeadPtr, flushRangeTailPtr,
    input  alReadEn, alReadPtr,
    output alReadWriteReg, alReadLogDst, alReadPrevPhyDst,
    input  rmtWriteEn, rmtWriteLogReg, rmtWritePhyReg,
    input  renameLogicRecoveryRMT
  );

endinterface

// File: rtl/rmt_recovery_walker.sv
// Walks the flushed ActiveList range youngest-to-oldest, WALK_WIDTH entries per cycle,
// restoring each entry's previous physical mapping into the RMT one cycle later.
module rmt_recovery_walker #(
  parameter int AL_INDEX_WIDTH = 6,
  parameter int WALK_WIDTH     = 2,
  parameter int LREG_WIDTH     = 5,
  parameter int PREG_WIDTH     = 7
) (
  input logic                  clk,
  input logic                  rst,
  rmt_recovery_walker_if.master bus
);

  typedef enum logic {IDLE, WALK} state_t;

  state_t                              state, stateNext;
  logic [AL_INDEX_WIDTH-1:0]           remaining, remainingNext;
  logic [AL_INDEX_WIDTH-1:0]           walkPtr, walkPtrNext;
  logic [AL_INDEX_WIDTH-1:0]           issueCnt;
  logic [AL_INDEX_WIDTH-1:0]           flushCount;
  logic [WALK_WIDTH-1:0]               laneIssue;
  logic [WALK_WIDTH-1:0]               pipeValid;
  logic [WALK_WIDTH-1:0]               writeEn;
  logic [WALK_WIDTH-1:0][AL_INDEX_WIDTH-1:0] readPtr;
  logic                                busy;

  // Index subtraction wraps naturally at 2^AL_INDEX_WIDTH.
  assign flushCount = bus.flushRangeTailPtr - bus.flushRangeHeadPtr;
  assign busy       = (state == WALK) || (|pipeValid);

  // NOTE: every combinational output gets a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    walkPtrNext   = walkPtr;
    laneIssue     = '0;
    issueCnt      = '0;
    unique case (state)
      IDLE: begin
        if (bus.toRecoveryPhase && !busy) begin
          remainingNext = flushCount;
          walkPtrNext   = bus.flushRangeTailPtr;
          if (flushCount != '0) stateNext = WALK;
        end
      end
      WALK: begin
        for (int i = 0; i < WALK_WIDTH; i++) begin
          laneIssue[i] = (remaining > AL_INDEX_WIDTH'(i));
          if (laneIssue[i]) issueCnt = issueCnt + AL_INDEX_WIDTH'(1);
        end
        remainingNext = remaining - issueCnt;
        walkPtrNext   = walkPtr - issueCnt;
        if (remainingNext == '0) stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < WALK_WIDTH; i++) begin
      readPtr[i] = walkPtr - AL_INDEX_WIDTH'(i + 1);
    end
  end

  // Within one beat the highest lane is the oldest entry, so it alone restores a
  // register that several lanes target.
  always_comb begin
    writeEn = '0;
    for (int i = 0; i < WALK_WIDTH; i++) begin
      writeEn[i] = pipeValid[i] & bus.alReadWriteReg[i];
      for (int j = i + 1; j < WALK_WIDTH; j++) begin
        if (pipeValid[j] && bus.alReadWriteReg[j] &&
            (bus.alReadLogDst[j] == bus.alReadLogDst[i])) begin
          writeEn[i] = 1'b0;
        end
      end
    end
  end

  assign bus.alReadEn               = laneIssue;
  assign bus.alReadPtr              = readPtr;
  assign bus.rmtWriteEn             = writeEn;
  assign bus.rmtWriteLogReg         = bus.alReadLogDst;
  assign bus.rmtWritePhyReg         = bus.alReadPrevPhyDst;
  assign bus.renameLogicRecoveryRMT = busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      walkPtr   <= '0;
      pipeValid <= '0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
      walkPtr   <= walkPtrNext;
      pipeValid <= laneIssue;
    end
  end

  // A start pulse while busy is dropped; flag it in simulation.
  startWhileBusy: assert property (@(posedge clk) disable iff (rst)
                                   !(bus.toRecoveryPhase && busy));

endmodule

// File: tb/tb_rmt_recovery_walker.sv
// Self-checking bench: table of flush ranges, per-cycle expectations queued from an
// ActiveList model, plus hand-written reset sequences.
module tb_rmt_recovery_walker;

  localparam int AW = 6;
  localparam int WW = 2;
  localparam int LW = 5;
  localparam int PW = 7;
  localparam int AL_SIZE = 1 << AW;
  localparam int NREG = 1 << LW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rmt_recovery_walker_if #(.AL_INDEX_WIDTH(AW), .WALK_WIDTH(WW),
                           .LREG_WIDTH(LW), .PREG_WIDTH(PW)) bus ();

  rmt_recovery_walker #(.AL_INDEX_WIDTH(AW), .WALK_WIDTH(WW),
                        .LREG_WIDTH(LW), .PREG_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic                   busy;
    logic [WW-1:0]          rdEn;
    logic [WW-1:0][AW-1:0]  rdPtr;
    logic [WW-1:0]          wrEn;
    logic [WW-1:0][LW-1:0]  wrLog;
    logic [WW-1:0][PW-1:0]  wrPhy;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    int            pattern;   // 0 distinct, 1 random, 2 same-reg pair, 3 lane0 no-write
    int            expBusy;   // cycles renameLogicRecoveryRMT is high
  } vec_t;

  cyc_t expQ[$];

  logic          memWr   [AL_SIZE];
  logic [LW-1:0] memLog  [AL_SIZE];
  logic [PW-1:0] memPrev [AL_SIZE];

  logic [PW-1:0] rmtModel [NREG];
  logic [NREG-1:0] rmtTouched;
  logic [PW-1:0] rmtExp [NREG];
  logic [NREG-1:0] rmtSeen;

  logic [WW-1:0]         reqEn;
  logic [WW-1:0][AW-1:0] reqPtr;
  int busyCount;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fillMem(input int pattern);
    for (int k = 0; k < AL_SIZE; k++) begin
      if (pattern == 1) begin
        memWr[k]   = 1'($urandom);
        memLog[k]  = LW'($urandom);
        memPrev[k] = PW'($urandom);
      end else begin
        memWr[k]   = 1'b1;
        memLog[k]  = LW'(k % NREG);
        memPrev[k] = PW'(k + 1);
      end
    end
    if (pattern == 2) begin
      memWr[21] = 1'b1; memLog[21] = 5'd5; memPrev[21] = 7'd20;
      memWr[20] = 1'b1; memLog[20] = 5'd5; memPrev[20] = 7'd9;
    end
    if (pattern == 3) memWr[31] = 1'b0;
  endtask

  // Final RMT contents: for each register, the oldest flushed entry that writes it.
  task automatic buildRmtExpect(input logic [AW-1:0] head, input logic [AW-1:0] tail);
    logic [AW-1:0] idx;
    int rem;
    rem = int'(AW'(tail - head));
    rmtSeen = '0;
    for (int r = 0; r < NREG; r++) rmtExp[r] = '0;
    for (int off = 0; off < rem; off++) begin
      idx = head + AW'(off);
      if (memWr[idx] && !rmtSeen[memLog[idx]]) begin
        rmtSeen[memLog[idx]] = 1'b1;
        rmtExp[memLog[idx]]  = memPrev[idx];
      end
    end
  endtask

  // Cycle-by-cycle expectation, starting with the pulse cycle itself.
  task automatic pushTrace(input logic [AW-1:0] head, input logic [AW-1:0] tail);
    cyc_t c;
    logic [AW-1:0] ptr;
    logic [WW-1:0] prevEn;
    logic [WW-1:0][AW-1:0] prevPtr;
    logic [WW-1:0] rawEn;
    int rem, n;
    rem = int'(AW'(tail - head));
    ptr = tail;
    prevEn = '0;
    prevPtr = '0;
    expQ.push_back(cyc_t'(0));
    while (rem != 0 || prevEn != '0) begin
      c = '0;
      c.busy = 1'b1;
      n = 0;
      for (int i = 0; i < WW; i++) begin
        if (i < rem) begin
          c.rdEn[i]  = 1'b1;
          c.rdPtr[i] = ptr - AW'(i + 1);
          n++;
        end
      end
      for (int i = 0; i < WW; i++) begin
        rawEn[i] = prevEn[i] && memWr[prevPtr[i]];
        c.wrLog[i] = memLog[prevPtr[i]];
        c.wrPhy[i] = memPrev[prevPtr[i]];
      end
      for (int i = 0; i < WW; i++) begin
        c.wrEn[i] = rawEn[i];
        for (int j = 0; j < WW; j++)
          if (j > i && rawEn[j] && c.wrLog[j] == c.wrLog[i]) c.wrEn[i] = 1'b0;
      end
      expQ.push_back(c);
      prevEn  = c.rdEn;
      prevPtr = c.rdPtr;
      ptr = ptr - AW'(n);
      rem = rem - n;
    end
    expQ.push_back(cyc_t'(0));
    expQ.push_back(cyc_t'(0));
  endtask

  task automatic compareCycle(input cyc_t c);
    check("busy", 32'(bus.renameLogicRecoveryRMT), 32'(c.busy));
    check("alReadEn", 32'(bus.alReadEn), 32'(c.rdEn));
    check("rmtWriteEn", 32'(bus.rmtWriteEn), 32'(c.wrEn));
    for (int i = 0; i < WW; i++) begin
      if (c.rdEn[i]) check($sformatf("alReadPtr[%0d]", i), 32'(bus.alReadPtr[i]), 32'(c.rdPtr[i]));
      if (c.wrEn[i]) begin
        check($sformatf("rmtWriteLogReg[%0d]", i), 32'(bus.rmtWriteLogReg[i]), 32'(c.wrLog[i]));
        check($sformatf("rmtWritePhyReg[%0d]", i), 32'(bus.rmtWritePhyReg[i]), 32'(c.wrPhy[i]));
      end
    end
  endtask

  // One clock: answer last cycle's reads, drive the pulse, then sample at negedge.
  task automatic tick(input logic pulse);
    cyc_t c;
    @(posedge clk);
    #1;
    for (int i = 0; i < WW; i++) begin
      if (reqEn[i]) begin
        bus.alReadWriteReg[i]   = memWr[reqPtr[i]];
        bus.alReadLogDst[i]     = memLog[reqPtr[i]];
        bus.alReadPrevPhyDst[i] = memPrev[reqPtr[i]];
      end else begin
        bus.alReadWriteReg[i]   = 1'b1;
        bus.alReadLogDst[i]     = LW'($urandom);
        bus.alReadPrevPhyDst[i] = PW'($urandom);
      end
    end
    bus.toRecoveryPhase = pulse;
    @(negedge clk);
    if (expQ.size() > 0) begin
      c = expQ.pop_front();
      compareCycle(c);
    end
    for (int i = 0; i < WW; i++) begin
      if (bus.rmtWriteEn[i]) begin
        rmtModel[bus.rmtWriteLogReg[i]]   = bus.rmtWritePhyReg[i];
        rmtTouched[bus.rmtWriteLogReg[i]] = 1'b1;
      end
    end
    if (bus.renameLogicRecoveryRMT) busyCount++;
    reqEn  = bus.alReadEn;
    reqPtr = bus.alReadPtr;
  endtask

  task automatic checkQuiet(input string name);
    check({name, "_alReadEn"}, 32'(bus.alReadEn), 32'd0);
    check({name, "_rmtWriteEn"}, 32'(bus.rmtWriteEn), 32'd0);
    check({name, "_busy"}, 32'(bus.renameLogicRecoveryRMT), 32'd0);
  endtask

  task automatic runVector(input vec_t v, input int id);
    fillMem(v.pattern);
    buildRmtExpect(v.head, v.tail);
    for (int r = 0; r < NREG; r++) rmtModel[r] = '0;
    rmtTouched = '0;
    busyCount = 0;
    bus.flushRangeHeadPtr = v.head;
    bus.flushRangeTailPtr = v.tail;
    pushTrace(v.head, v.tail);
    tick(1'b1);
    for (int n = 0; n < 200 && expQ.size() > 0; n++) tick(1'b0);
    check($sformatf("v%0d_drained", id), 32'(expQ.size()), 32'd0);
    expQ.delete();
    check($sformatf("v%0d_busyCycles", id), 32'(busyCount), 32'(v.expBusy));
    check($sformatf("v%0d_rmtTouched", id), rmtTouched, rmtSeen);
    for (int r = 0; r < NREG; r++)
      if (rmtSeen[r]) check($sformatf("v%0d_rmt[%0d]", id, r), 32'(rmtModel[r]), 32'(rmtExp[r]));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{head: 6'd3,  tail: 6'd7,  pattern: 0, expBusy: 3};
    vecs[1] = '{head: 6'd62, tail: 6'd1,  pattern: 0, expBusy: 3};
    vecs[2] = '{head: 6'd10, tail: 6'd10, pattern: 0, expBusy: 0};
    vecs[3] = '{head: 6'd20, tail: 6'd22, pattern: 2, expBusy: 2};
    vecs[4] = '{head: 6'd30, tail: 6'd32, pattern: 3, expBusy: 2};
    vecs[5] = '{head: 6'd0,  tail: 6'd63, pattern: 1, expBusy: 33};
    vecs[6] = '{head: 6'd40, tail: 6'd49, pattern: 1, expBusy: 6};
    vecs[7] = '{head: 6'd5,  tail: 6'd9,  pattern: 1, expBusy: 3};

    bus.toRecoveryPhase   = 1'b0;
    bus.flushRangeHeadPtr = '0;
    bus.flushRangeTailPtr = '0;
    bus.alReadWriteReg    = '0;
    bus.alReadLogDst      = '0;
    bus.alReadPrevPhyDst  = '0;
    reqEn  = '0;
    reqPtr = '0;
    rmtTouched = '0;

    // Outputs must be quiet while reset is held, even with a pulse applied.
    repeat (2) @(posedge clk);
    bus.toRecoveryPhase = 1'b1;
    bus.flushRangeTailPtr = 6'd4;
    @(negedge clk);
    checkQuiet("inReset");
    @(negedge clk);
    bus.toRecoveryPhase = 1'b0;
    rst = 1'b0;
    repeat (2) tick(1'b0);
    checkQuiet("afterReset");

    for (int v = 0; v < 7; v++) runVector(vecs[v], v);

    // Reset in the middle of an 8-entry walk aborts it at once.
    fillMem(1);
    bus.flushRangeHeadPtr = 6'd0;
    bus.flushRangeTailPtr = 6'd8;
    tick(1'b1);
    tick(1'b0);
    check("midWalk_rdEn1", 32'(bus.alReadEn), 32'd3);
    tick(1'b0);
    check("midWalk_rdEn2", 32'(bus.alReadEn), 32'd3);
    check("midWalk_wrEn2", 32'(bus.rmtWriteEn), 32'(memWr[7] | (memWr[6] << 1)) &
          ((memLog[7] == memLog[6] && memWr[6]) ? 32'd2 : 32'd3));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkQuiet("resetAbort");
    @(negedge clk);
    rst = 1'b0;
    reqEn = '0;
    for (int n = 0; n < 6; n++) begin
      tick(1'b0);
      checkQuiet($sformatf("postAbort%0d", n));
    end

    runVector(vecs[7], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
